// File: rtl/hub75_panel_monitor_if.sv
// HUB75 panel bus: pixel clock, row latch, output enable, row address and RGB data.
// The scan driver (or bench) owns the master side; the panel monitor listens on the slave side.
interface hub75_panel_monitor_if #(
  parameter int ROW_BITS = 4
);
  logic                hub_clk;
  logic                hub_latch;
  logic                hub_oe;
  logic [ROW_BITS-1:0] hub_row;
  logic [5:0]          hub_rgb;

  modport master (
    output hub_clk,
    output hub_latch,
    output hub_oe,
    output hub_row,
    output hub_rgb
  );

  modport slave (
    input hub_clk,
    input hub_latch,
    input hub_oe,
    input hub_row,
    input hub_rgb
  );
endinterface

// File: rtl/hub75_panel_monitor.sv
// HUB75 panel-side monitor: oversamples the row-scan bus, rebuilds each shifted
// line with its row address, measures every OE pulse and flags protocol errors.
module hub75_panel_monitor #(
  parameter int COLUMNS       = 64,
  parameter int ROW_BITS      = 4,
  parameter int OE_WIDTH_BITS = 12,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                       clk_in,
  input  logic                       reset,
  hub75_panel_monitor_if.slave       hub,
  input  logic                       err_clear,
  output logic [COLUMNS*6-1:0]       line_data,
  output logic [ROW_BITS-1:0]        line_row,
  output logic [$clog2(COLUMNS):0]   line_count,
  output logic                       line_valid,
  output logic [OE_WIDTH_BITS-1:0]   oe_width,
  output logic [ROW_BITS-1:0]        oe_row,
  output logic                       oe_valid,
  output logic                       err_count_mismatch,
  output logic                       err_latch_during_oe
);
  localparam int CW = $clog2(COLUMNS) + 1;
  localparam int LW = COLUMNS * 6;
  localparam int IW = ROW_BITS + 9;
  localparam int OW = OE_WIDTH_BITS;

  typedef enum logic [0:0] {
    OE_IDLE = 1'b0,
    OE_ON   = 1'b1
  } oe_state_e;

  // Whole bus travels through one synchronizer chain so data, row and strobes stay aligned.
  logic [IW-1:0]                  pins_s;
  logic [SYNC_STAGES-1:0][IW-1:0] sync_q, sync_d;
  logic [2:0]                     dly_q, dly_d;
  logic [IW-1:0]                  samp_s;
  logic                           clk_rise_s, latch_rise_s, oe_s, oe_rise_s, oe_fall_s;
  logic [ROW_BITS-1:0]            row_s;
  logic [5:0]                     rgb_s;

  logic [LW-1:0]       shift_q, shift_d, line_data_q, line_data_d;
  logic [CW-1:0]       cnt_q, cnt_d, line_count_q, line_count_d, cnt_shift_s;
  logic [ROW_BITS-1:0] line_row_q, line_row_d;
  logic                line_valid_q, line_valid_d;
  logic                arm_q, arm_d;
  logic                err_cm_q, err_cm_d, err_lo_q, err_lo_d;

  oe_state_e           state_q, state_d;
  logic [OW-1:0]       width_q, width_d, oe_width_q, oe_width_d;
  logic [ROW_BITS-1:0] hold_row_q, hold_row_d, oe_row_q, oe_row_d;
  logic                oe_valid_q, oe_valid_d;

  assign pins_s = {hub.hub_clk, hub.hub_latch, hub.hub_oe, hub.hub_row, hub.hub_rgb};
  assign samp_s = sync_q[SYNC_STAGES-1];
  assign oe_s   = samp_s[IW-3];
  assign row_s  = samp_s[6 +: ROW_BITS];
  assign rgb_s  = samp_s[5:0];

  assign clk_rise_s   = samp_s[IW-1] & ~dly_q[2];
  assign latch_rise_s = samp_s[IW-2] & ~dly_q[1];
  assign oe_rise_s    = oe_s & ~dly_q[0];
  assign oe_fall_s    = ~oe_s & dly_q[0];

  // Next values of the synchronizer chain and the edge-detect stage.
  always_comb begin
    sync_d[0] = pins_s;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    dly_d = samp_s[IW-1:IW-3];
  end

  // Line reassembly and error flags; a same-sample shift is folded in before the latch copy.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    line_data_d  = line_data_q;
    line_count_d = line_count_q;
    line_row_d   = line_row_q;
    line_valid_d = 1'b0;
    arm_d        = arm_q;
    err_cm_d     = err_cm_q;
    err_lo_d     = err_lo_q;
    cnt_shift_s  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    if (err_clear) begin
      err_cm_d = 1'b0;
      err_lo_d = 1'b0;
    end else begin
      err_cm_d = err_cm_q;
      err_lo_d = err_lo_q;
    end

    if (clk_rise_s) begin
      shift_d = {shift_q[LW-7:0], rgb_s};
      cnt_d   = cnt_shift_s;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end

    if (latch_rise_s) begin
      line_data_d  = shift_d;
      line_count_d = cnt_d;
      line_row_d   = row_s;
      line_valid_d = 1'b1;
      arm_d        = 1'b1;
      // Only lines that follow an earlier latch are complete enough to be checked.
      if (arm_q && (cnt_d != CW'(COLUMNS))) begin
        err_cm_d = 1'b1;
      end else begin
        err_cm_d = err_cm_d;
      end
      if (oe_s) begin
        err_lo_d = 1'b1;
      end else begin
        err_lo_d = err_lo_d;
      end
      cnt_d = {CW{1'b0}};
    end else begin
      line_valid_d = 1'b0;
    end
  end

  // OE FSM state register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= OE_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // OE FSM next-state: a pulse runs from synchronized rise to synchronized fall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OE_IDLE: state_d = oe_rise_s ? OE_ON : OE_IDLE;
      OE_ON:   state_d = oe_fall_s ? OE_IDLE : OE_ON;
      default: state_d = OE_IDLE;
    endcase
  end

  // OE FSM outputs: count high cycles with saturation, publish on the falling edge.
  always_comb begin
    width_d    = width_q;
    hold_row_d = hold_row_q;
    oe_width_d = oe_width_q;
    oe_row_d   = oe_row_q;
    oe_valid_d = 1'b0;
    case (state_q)
      OE_IDLE: begin
        if (oe_rise_s) begin
          width_d    = OW'(1);
          hold_row_d = row_s;
        end else begin
          width_d = width_q;
        end
      end
      OE_ON: begin
        if (oe_fall_s) begin
          oe_width_d = width_q;
          oe_row_d   = hold_row_q;
          oe_valid_d = 1'b1;
        end else if (width_q != {OW{1'b1}}) begin
          width_d = width_q + OW'(1);
        end else begin
          width_d = width_q;
        end
      end
      default: begin
        width_d = {OW{1'b0}};
      end
    endcase
  end

  // Datapath and output registers; reset discards any OE pulse in flight.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      dly_q        <= 3'b000;
      shift_q      <= '0;
      cnt_q        <= '0;
      line_data_q  <= '0;
      line_count_q <= '0;
      line_row_q   <= '0;
      line_valid_q <= 1'b0;
      arm_q        <= 1'b0;
      err_cm_q     <= 1'b0;
      err_lo_q     <= 1'b0;
      width_q      <= '0;
      hold_row_q   <= '0;
      oe_width_q   <= '0;
      oe_row_q     <= '0;
      oe_valid_q   <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      dly_q        <= dly_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      line_data_q  <= line_data_d;
      line_count_q <= line_count_d;
      line_row_q   <= line_row_d;
      line_valid_q <= line_valid_d;
      arm_q        <= arm_d;
      err_cm_q     <= err_cm_d;
      err_lo_q     <= err_lo_d;
      width_q      <= width_d;
      hold_row_q   <= hold_row_d;
      oe_width_q   <= oe_width_d;
      oe_row_q     <= oe_row_d;
      oe_valid_q   <= oe_valid_d;
    end
  end

  assign line_data           = line_data_q;
  assign line_row            = line_row_q;
  assign line_count          = line_count_q;
  assign line_valid          = line_valid_q;
  assign oe_width            = oe_width_q;
  assign oe_row              = oe_row_q;
  assign oe_valid            = oe_valid_q;
  assign err_count_mismatch  = err_cm_q;
  assign err_latch_during_oe = err_lo_q;
endmodule

// File: tb/tb_hub75_panel_monitor.sv
// Bench for hub75_panel_monitor: drives a HUB75 bus with random lines and OE
// pulses and compares every published line / OE result against a queue model.
module tb_hub75_panel_monitor;
  localparam int COLUMNS = 64;
  localparam int RB      = 4;
  localparam int OWB     = 12;
  localparam int CW      = 7;
  localparam int LW      = COLUMNS * 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           err_clear;
  logic [LW-1:0]  line_data;
  logic [RB-1:0]  line_row, oe_row;
  logic [CW-1:0]  line_count;
  logic           line_valid, oe_valid, err_cm, err_lo;
  logic [OWB-1:0] oe_width;

  hub75_panel_monitor_if #(.ROW_BITS(RB)) hif ();

  hub75_panel_monitor #(
    .COLUMNS(COLUMNS), .ROW_BITS(RB), .OE_WIDTH_BITS(OWB), .SYNC_STAGES(2)
  ) dut (
    .clk_in(clk), .reset(rst_n), .hub(hif), .err_clear(err_clear),
    .line_data(line_data), .line_row(line_row), .line_count(line_count),
    .line_valid(line_valid), .oe_width(oe_width), .oe_row(oe_row),
    .oe_valid(oe_valid), .err_count_mismatch(err_cm), .err_latch_during_oe(err_lo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pixels seen since reset (newest last), shifts since last latch, flags.
  logic [5:0] hist[$];
  int         m_cnt = 0;
  bit         m_arm = 1'b0, m_cm = 1'b0, m_lo = 1'b0;

  // Output capture at each valid pulse.
  int             lv_cnt = 0, ov_cnt = 0;
  logic [LW-1:0]  cap_data;
  logic [RB-1:0]  cap_row, cap_oer;
  logic [CW-1:0]  cap_cnt;
  logic           cap_cm, cap_lo;
  logic [OWB-1:0] cap_oew;

  always begin
    @(posedge clk);
    #1;
    if (line_valid === 1'b1) begin
      lv_cnt++;
      cap_data = line_data; cap_row = line_row; cap_cnt = line_count;
      cap_cm = err_cm; cap_lo = err_lo;
    end
    if (oe_valid === 1'b1) begin
      ov_cnt++;
      cap_oew = oe_width; cap_oer = oe_row;
    end
  end

  task automatic model_reset();
    hist.delete();
    m_cnt = 0; m_arm = 1'b0; m_cm = 1'b0; m_lo = 1'b0;
  endtask

  task automatic shift_px(input logic [5:0] v, input logic [RB-1:0] row);
    @(negedge clk);
    hif.hub_rgb = v; hif.hub_row = row; hif.hub_clk = 1'b1;
    repeat (2) @(negedge clk);
    hif.hub_clk = 1'b0;
    @(negedge clk);
    hist.push_back(v);
    if (hist.size() > COLUMNS) void'(hist.pop_front());
    if (m_cnt < 127) m_cnt++;
  endtask

  task automatic do_latch(input logic [RB-1:0] row);
    logic [LW-1:0] exp_data;
    int            exp_cnt, start;
    bit            got;
    exp_data = '0;
    for (int i = 0; i < COLUMNS; i++) begin
      if (hist.size() > i) exp_data[6*i +: 6] = hist[hist.size()-1-i];
    end
    exp_cnt = m_cnt;
    if (m_arm && (m_cnt != COLUMNS)) m_cm = 1'b1;
    if (hif.hub_oe) m_lo = 1'b1;
    m_arm = 1'b1; m_cnt = 0;
    start = lv_cnt;
    @(negedge clk);
    hif.hub_row = row; hif.hub_latch = 1'b1;
    repeat (2) @(negedge clk);
    hif.hub_latch = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (lv_cnt != start) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("line_seen", got, 1'b1);
    check_eq("line_data", cap_data, exp_data);
    check_eq("line_row", cap_row, row);
    check_eq("line_count", cap_cnt, exp_cnt);
    check_eq("err_count_mismatch", cap_cm, m_cm);
    check_eq("err_latch_during_oe", cap_lo, m_lo);
    @(negedge clk);
    check_eq("line_valid_one_cycle", line_valid, 1'b0);
    check_eq("line_pulse_count", lv_cnt - start, 1);
  endtask

  task automatic clear_err();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
    m_cm = 1'b0; m_lo = 1'b0;
    @(negedge clk);
    check_eq("flags_after_clear", {err_cm, err_lo}, 2'b00);
  endtask

  task automatic oe_pulse(input int n, input logic [RB-1:0] row);
    int start, exp_w, w;
    bit got;
    start = ov_cnt;
    @(negedge clk);
    hif.hub_row = row; hif.hub_oe = 1'b1;
    repeat (n) @(negedge clk);
    hif.hub_oe = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ov_cnt != start) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check_eq("oe_seen", got, 1'b1);
    exp_w = (n > 4095) ? 4095 : n;
    w = int'(cap_oew);
    check_eq("oe_width", ((w >= exp_w - 1) && (w <= exp_w + 1)) ? exp_w : w, exp_w);
    check_eq("oe_row", cap_oer, row);
    @(negedge clk);
    check_eq("oe_pulse_count", ov_cnt - start, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {line_data, line_row, line_count, line_valid, oe_width, oe_row,
                   oe_valid, err_cm, err_lo}, '0);
  endtask

  initial begin
    int n, start;
    logic [RB-1:0] r;
    rst_n = 1'b0; err_clear = 1'b0;
    hif.hub_clk = 1'b0; hif.hub_latch = 1'b0; hif.hub_oe = 1'b0;
    hif.hub_row = '0; hif.hub_rgb = '0;
    model_reset();
    repeat (5) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First latch arms the checker; then a full line with rgb = column index.
    do_latch(4'd0);
    for (int k = 0; k < COLUMNS; k++) shift_px(6'(COLUMNS - 1 - k), 4'd5);
    do_latch(4'd5);
    check_eq("slice10_direct", cap_data[60 +: 6], 6'd10);

    // Short line flags a mismatch that stays until cleared.
    for (int k = 0; k < 63; k++) shift_px(6'($urandom_range(0, 63)), 4'd7);
    do_latch(4'd7);
    repeat (10) @(negedge clk);
    check_eq("mismatch_sticky", err_cm, 1'b1);
    clear_err();

    // Line counter saturation.
    for (int k = 0; k < 130; k++) shift_px(6'($urandom_range(0, 63)), 4'd2);
    do_latch(4'd2);
    clear_err();

    // OE pulse measurement and saturation.
    oe_pulse(736, 4'd3);
    oe_pulse(5000, 4'd9);

    // Latch while OE is high.
    r = 4'($urandom_range(0, 15));
    for (int k = 0; k < COLUMNS; k++) shift_px(6'($urandom_range(0, 63)), r);
    @(negedge clk);
    hif.hub_row = r; hif.hub_oe = 1'b1;
    repeat (6) @(negedge clk);
    do_latch(r);
    start = ov_cnt;
    hif.hub_oe = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("oe_after_latch_seen", ov_cnt - start, 1);
    check_eq("oe_after_latch_row", cap_oer, r);
    clear_err();

    // Randomized lines and OE pulses.
    for (int it = 0; it < 8; it++) begin
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : COLUMNS;
      r = 4'($urandom_range(0, 15));
      for (int k = 0; k < n; k++) shift_px(6'($urandom_range(0, 63)), r);
      do_latch(r);
      oe_pulse($urandom_range(2, 60), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) clear_err();
    end

    // Reset in the middle of a line and an OE pulse.
    for (int k = 0; k < 5; k++) shift_px(6'($urandom_range(0, 63)), 4'd1);
    do_latch(4'd1);
    for (int k = 0; k < 30; k++) shift_px(6'($urandom_range(0, 63)), 4'd4);
    @(negedge clk);
    hif.hub_oe = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midop_reset_outputs");
    @(negedge clk);
    hif.hub_oe = 1'b0; hif.hub_clk = 1'b0; hif.hub_latch = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    start = ov_cnt;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("no_oe_after_reset", ov_cnt - start, 0);
    for (int k = 0; k < 10; k++) shift_px(6'($urandom_range(0, 63)), 4'd6);
    do_latch(4'd6);
    for (int k = 0; k < COLUMNS; k++) shift_px(6'($urandom_range(0, 63)), 4'd8);
    do_latch(4'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
